palette_loader: RTL and testbench



---
 rtl/palette_loader.sv | 84 ++++++++
 tb/tb_palette_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
// palette_loader: copies a run of 16-bit words from system memory into the palette write port.
module palette_loader #(
  parameter int SRC_WIDTH = 16,
  parameter int DST_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SRC_WIDTH-1:0] src_base,
  input  logic [DST_WIDTH-1:0] dst_base,
  input  logic [DST_WIDTH:0]   word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 src_req,
  output logic [SRC_WIDTH-1:0] src_addr,
  input  logic                 src_grant,
  input  logic [15:0]          src_rdata,
  output logic                 pal_en,
  output logic                 pal_write,
  output logic [DST_WIDTH-1:0] pal_addr,
  output logic [15:0]          pal_wdata
);
  typedef enum logic [2:0] {IDLE, REQ, DATA, WRITE, FIN} state_t;
  state_t               state_q, state_d;
  logic [SRC_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [DST_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [DST_WIDTH:0]   rem_q, rem_d;
  logic [15:0]          data_q, data_d;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    data_d    = data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (word_count == '0) ? FIN : REQ;
        if (word_count != '0) begin
          src_ptr_d = src_base;
          dst_ptr_d = dst_base;
          rem_d     = word_count;
        end
      end
      REQ: state_d = abort ? IDLE : (src_grant ? DATA : REQ);
      DATA: begin
        state_d = abort ? IDLE : WRITE;
        data_d  = src_rdata;
      end
      WRITE: if (abort) state_d = IDLE;
      else begin
        src_ptr_d = src_ptr_q + SRC_WIDTH'(1);
        dst_ptr_d = dst_ptr_q + DST_WIDTH'(1);
        rem_d     = rem_q - (DST_WIDTH+1)'(1);
        state_d   = (rem_q == (DST_WIDTH+1)'(1)) ? FIN : REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  // abort may combinationally squash the write strobe; grant/rdata never reach outputs
  assign busy      = (state_q == REQ) || (state_q == DATA) || (state_q == WRITE);
  assign done      = (state_q == FIN);
  assign src_req   = (state_q == REQ);
  assign src_addr  = (state_q == REQ) ? src_ptr_q : '0;
  assign pal_en    = (state_q == WRITE) && !abort;
  assign pal_write = pal_en;
  assign pal_addr  = (state_q == WRITE) ? dst_ptr_q : '0;
  assign pal_wdata = (state_q == WRITE) ? data_q : '0;
endmodule

// File: tb/tb_palette_loader.sv
// tb_palette_loader: randomized scoreboard bench for palette_loader.
module tb_palette_loader;
  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic [15:0] src_base = 0;
  logic [9:0] dst_base = 0;
  logic [10:0] word_count = 0;
  logic busy, done, src_req, pal_en, pal_write;
  logic src_grant = 0;
  logic [15:0] src_addr, pal_wdata;
  logic [15:0] src_rdata = 0;
  logic [9:0] pal_addr;

  palette_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .word_count(word_count),
    .busy(busy), .done(done), .src_req(src_req), .src_addr(src_addr),
    .src_grant(src_grant), .src_rdata(src_rdata), .pal_en(pal_en),
    .pal_write(pal_write), .pal_addr(pal_addr), .pal_wdata(pal_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, waits = 0, writes = 0, wcnt = 0, fixed_wait = 0;
  bit req_seen, busy_seen, done_seen, pend;
  bit seen [1024];
  logic [15:0] pend_a;
  logic [9:0]  exp_a [$];
  logic [15:0] exp_d [$];
  logic [15:0] exp_s [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) cyc++;

  // arbiter + memory model: data appears the cycle after a grant, garbage otherwise
  always @(negedge clk) begin
    src_rdata = pend ? 16'hA000 + pend_a : 16'($urandom);
    pend = 0;
    if (src_req) begin
      req_seen = 1;
      chk("src_req_expected", 32'(exp_s.size() != 0), 1);
      if (wcnt == 0) begin
        src_grant = 1;
        pend = 1;
        pend_a = src_addr;
        if (exp_s.size() != 0) chk("src_addr", src_addr, exp_s.pop_front());
      end else begin
        src_grant = 0;
        wcnt--;
        waits++;
        if (exp_s.size() != 0) chk("src_addr_stable", src_addr, exp_s[0]);
      end
    end else begin
      src_grant = 0;
      wcnt = pick_wait();
    end
  end

  // palette-side monitor
  always @(negedge clk) begin
    if (busy) busy_seen = 1;
    if (done) begin
      done_seen = 1;
      chk("done_queue_empty", exp_a.size(), 0);
    end
    if (pal_en) begin
      writes++;
      seen[pal_addr] = 1;
      chk("pal_write", pal_write, 1);
      chk("write_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) begin
        chk("pal_addr", pal_addr, exp_a.pop_front());
        chk("pal_wdata", pal_wdata, exp_d.pop_front());
      end
    end
  end

  task automatic launch(input logic [15:0] s, input logic [9:0] d, input int n, input bit with_abort);
    @(posedge clk);
    #2;
    t0 = cyc;
    src_base = s; dst_base = d; word_count = 11'(n);
    start = 1; abort = with_abort;
    for (int i = 0; i < n; i++) begin
      exp_s.push_back(s + 16'(i));
      exp_a.push_back(d + 10'(i));
      exp_d.push_back(16'hA000 + s + 16'(i));
    end
    waits = 0; writes = 0; req_seen = 0; busy_seen = 0; done_seen = 0;
    @(posedge clk);
    #2;
    start = 0; abort = 0;
  endtask

  task automatic finish_copy(input int n);
    int el;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) break;
      if (n != 0) chk("busy_during_copy", busy, 1);
    end
    el = cyc - t0;
    chk("cycles_to_done", el, (fixed_wait >= 0) ? 3 * n + 1 + fixed_wait * n : 3 * n + 1 + waits);
    chk("write_count", writes, n);
    chk("busy_at_done", busy, 0);
    chk("req_seen", req_seen, n != 0);
    chk("busy_seen", busy_seen, n != 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run(input logic [15:0] s, input logic [9:0] d, input int n);
    launch(s, d, n, 0);
    finish_copy(n);
  endtask

  task automatic flush();
    exp_a.delete(); exp_d.delete(); exp_s.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("reset_outputs", 32'(|{busy, done, src_req, pal_en, pal_write, src_addr, pal_addr, pal_wdata}), 0);

    fixed_wait = 0; run(16'h2000, 10'h010, 4);
    fixed_wait = 3; run(16'h2000, 10'h010, 4);
    fixed_wait = 0; run(16'hFFFF, 10'h3FE, 4);
    run(16'h1234, 10'h000, 0);
    launch(16'h3000, 10'h200, 2, 1); finish_copy(2);

    foreach (seen[i]) seen[i] = 0;
    run(16'h4000, 10'h155, 1024);
    c = 0;
    foreach (seen[i]) c += seen[i];
    chk("full_coverage", c, 1024);

    fixed_wait = -1;
    repeat (8) run(16'($urandom), 10'($urandom), int'($urandom_range(1, 20)));

    fixed_wait = -1;
    launch(16'h0100, 10'h020, 3, 0);
    @(posedge clk);
    #2;
    start = 1; src_base = 16'h9999; dst_base = 10'h003; word_count = 11'd7;
    @(posedge clk);
    #2 start = 0;
    finish_copy(3);

    fixed_wait = 0;
    launch(16'h0500, 10'h040, 4, 0);
    repeat (5) @(posedge clk);
    #2 abort = 1;
    @(posedge clk);
    #2 abort = 0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_writes", writes, 1);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_seen, 0);
    flush();

    launch(16'h0700, 10'h080, 8, 0);
    repeat (4) @(posedge clk);
    #2 reset_n = 0;
    flush();
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("reset_mid_outputs", 32'(|{busy, done, src_req, pal_en, pal_write, src_addr, pal_addr, pal_wdata}), 0);
    writes = 0; done_seen = 0;
    repeat (10) @(negedge clk);
    chk("reset_no_writes", writes, 0);
    chk("reset_no_done", done_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
